// File: rtl/counter_pkg.sv
// Shared FSM state encoding for the modulo counter.
package counter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;
endpackage

// File: rtl/mod_counter_next.sv
// Next-count arithmetic: load clamp, step, wrap and saturate; purely combinational.
module mod_counter_next #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             sat,
  input  logic             oneshot,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_next,
  output logic             term_step
);
  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic at_term;

  assign at_term   = up ? (count == MAX) : (count == ZERO);
  assign term_step = step && at_term;

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = (load_val > MAX) ? MAX : load_val;
    end else if (step) begin
      if (at_term) begin
        // A oneshot run parks on the terminal value rather than wrapping.
        if (!sat && !oneshot) begin
          count_next = up ? ZERO : MAX;
        end
      end else begin
        count_next = up ? (count + ONE) : (count - ONE);
      end
    end
  end
endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with IDLE/RUN/DONE control FSM, saturate/wrap and oneshot modes.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             oneshot,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);
  state_t           state;
  state_t           state_next;
  logic             step;
  logic             term_step;
  logic [WIDTH-1:0] count_next;

  assign step = (state == RUN) && en && !load;

  mod_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count      (count),
    .up         (up),
    .sat        (sat),
    .oneshot    (oneshot),
    .step       (step),
    .load       (load),
    .load_val   (load_val),
    .count_next (count_next),
    .term_step  (term_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stop is checked first everywhere so it wins over a simultaneous start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (stop)       state_next = IDLE;
        else if (start) state_next = RUN;
      end
      RUN: begin
        if (stop)                        state_next = IDLE;
        else if (term_step && oneshot)   state_next = DONE;
      end
      DONE: begin
        if (stop)       state_next = IDLE;
        else if (start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= count_next;
      tc    <= term_step;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: driver queues expected outputs, monitor compares after each edge.
module tb_mod_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, up = 1'b1, sat = 1'b0, oneshot = 1'b0;
  logic       start = 1'b0, stop = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] count;
  logic       tc, busy, done;

  int checks = 0;
  int failures = 0;
  int tag = 0;

  typedef struct {
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .oneshot  (oneshot),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int tg, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", nm, tg, act, req);
    end
  endtask

  // Queue the outputs expected after the next rising edge, then move to the following falling edge.
  task automatic tick(input logic [3:0] c, input logic t, input logic b, input logic d);
    exp_t e;
    e.count = c;
    e.tc    = t;
    e.busy  = b;
    e.done  = d;
    e.tag   = tag;
    tag++;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("count", mon_e.tag, 32'(count), 32'(mon_e.count));
      check("tc",    mon_e.tag, 32'(tc),    32'(mon_e.tc));
      check("busy",  mon_e.tag, 32'(busy),  32'(mon_e.busy));
      check("done",  mon_e.tag, 32'(done),  32'(mon_e.done));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset before any clock edge has happened.
    #2 reset = 1'b0;
    #1;
    check("rst_count", -1, 32'(count), 32'd0);
    check("rst_tc",    -1, 32'(tc),    32'd0);
    check("rst_busy",  -1, 32'(busy),  32'd0);
    check("rst_done",  -1, 32'(done),  32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Up count with wrap, modulus 10.
    start = 1'b1;
    tick(4'd0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    en    = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(4'(i % 10), (i % 10) == 0, 1'b1, 1'b0);
    end

    // Down count saturating at 0; load beats en in the same cycle.
    up = 1'b0; sat = 1'b1; load = 1'b1; load_val = 4'd2;
    tick(4'd2, 1'b0, 1'b1, 1'b0);
    load = 1'b0;
    tick(4'd1, 1'b0, 1'b1, 1'b0);
    tick(4'd0, 1'b0, 1'b1, 1'b0);
    tick(4'd0, 1'b1, 1'b1, 1'b0);
    tick(4'd0, 1'b1, 1'b1, 1'b0);

    // Load clamp and load-over-step priority.
    up = 1'b1; load = 1'b1; load_val = 4'd15;
    tick(4'd9, 1'b0, 1'b1, 1'b0);
    load_val = 4'd3;
    tick(4'd3, 1'b0, 1'b1, 1'b0);
    load = 1'b0; en = 1'b0;
    tick(4'd3, 1'b0, 1'b1, 1'b0);

    // Oneshot run into DONE, then restart from the held count.
    load = 1'b1; load_val = 4'd7;
    tick(4'd7, 1'b0, 1'b1, 1'b0);
    load = 1'b0; oneshot = 1'b1; sat = 1'b0; en = 1'b1;
    tick(4'd8, 1'b0, 1'b1, 1'b0);
    tick(4'd9, 1'b0, 1'b1, 1'b0);
    tick(4'd9, 1'b1, 1'b0, 1'b1);
    tick(4'd9, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    tick(4'd9, 1'b0, 1'b1, 1'b0);
    start = 1'b0; oneshot = 1'b0;
    tick(4'd0, 1'b1, 1'b1, 1'b0);

    // Down wrap from 0 to 9.
    up = 1'b0;
    tick(4'd9, 1'b1, 1'b1, 1'b0);
    tick(4'd8, 1'b0, 1'b1, 1'b0);

    // Reset asserted between edges mid-RUN at count 5.
    up = 1'b1; load = 1'b1; load_val = 4'd5;
    tick(4'd5, 1'b0, 1'b1, 1'b0);
    load = 1'b0; en = 1'b0;
    tick(4'd5, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_count", -2, 32'(count), 32'd0);
    check("mid_rst_tc",    -2, 32'(tc),    32'd0);
    check("mid_rst_busy",  -2, 32'(busy),  32'd0);
    check("mid_rst_done",  -2, 32'(done),  32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_count", -3, 32'(count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick(4'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; stop = 1'b1;
    tick(4'd0, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;
    tick(4'd0, 1'b0, 1'b1, 1'b0);
    start = 1'b0; stop = 1'b1;
    tick(4'd1, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;
    tick(4'd1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drain", -4, 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
